// File: rtl/fifo_bram_sync_param.sv
// fifo_bram_sync_param: single-clock block-RAM FIFO with count, almost flags and error pulses
// Ports: clock0/reset (sync, active-high); write/write_data push; read/read_data pop (registered);
//   empty, full, almost_full (count>=AFULL_THRESH), almost_empty (count<=AEMPTY_THRESH),
//   count (0..DEPTH), overflow/underflow (one-cycle pulse after a rejected write/read).
// Define FIFO_FWFT_EN for first-word fall-through: read_data shows the head word whenever empty=0.
module fifo_bram_sync_param #(
  parameter int DATA_WIDTH    = 36,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clock0,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DC = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE = AEMPTY_THRESH[ADDR_WIDTH:0];
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH || AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad
    initial $error("fifo_bram_sync_param: threshold out of range");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc, rd_acc, mem_rd, empty_nxt;
  always_comb begin
    wr_acc = write && !full;
    rd_acc = read && !empty;
`ifdef FIFO_FWFT_EN
    // count includes the head register; prefetch when RAM still holds words and the head is free or leaving
    mem_rd    = (count != CW'(!empty)) && (empty || read);
    empty_nxt = !mem_rd && (empty || read);
`else
    mem_rd    = rd_acc;
    empty_nxt = count_nxt == '0;
`endif
    count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
  end
  always_ff @(posedge clock0) begin
    if (!reset && wr_acc) mem[wr_ptr] <= write_data;
  end
  always_ff @(posedge clock0) begin
    if (reset) read_data <= '0;
    else if (mem_rd) read_data <= mem[rd_ptr];
  end
  always_ff @(posedge clock0) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + ADDR_WIDTH'(wr_acc);
      rd_ptr       <= rd_ptr + ADDR_WIDTH'(mem_rd);
      count        <= count_nxt;
      empty        <= empty_nxt;
      full         <= count_nxt == DC;
      almost_full  <= count_nxt >= AF;
      almost_empty <= count_nxt <= AE;
      overflow     <= write && full;
      underflow    <= read && empty;
    end
  end
endmodule

// File: tb/tb_fifo_bram_sync_param.sv
// tb_fifo_bram_sync_param: randomized check of fifo_bram_sync_param against a queue model
module tb_fifo_bram_sync_param;
  localparam int DW = 36;
  localparam int AW = 4;
  localparam int D = 16;
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;
  logic clock0 = 1'b0;
  logic reset = 1'b1, write = 1'b0, read = 1'b0;
  logic [DW-1:0] write_data = '0, read_data;
  logic empty, full, almost_full, almost_empty, overflow, underflow;
  logic [AW:0] count;
  ent_t q[$];
  logic [DW-1:0] rd_m = '0;
  int cyc = 0, passed = 0, total = 0;
  always #5 clock0 = ~clock0;
  fifo_bram_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut (
    .clock0(clock0), .reset(reset), .write(write), .write_data(write_data), .read(read),
    .read_data(read_data), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h at edge %0d", tag, got, exp, cyc);
  endtask
  function automatic bit shown();
`ifdef FIFO_FWFT_EN
    return q.size() > 0 && q[0].t <= cyc - 1;
`else
    return q.size() > 0;
`endif
  endfunction
  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction
  task automatic step(input bit rst, input bit w, input bit r, input logic [DW-1:0] d);
    bit sh, wacc, racc, ovm, unm;
    reset = rst;
    write = w;
    read = r;
    write_data = d;
    sh = shown();
    wacc = w && q.size() < D;
    racc = r && sh;
    ovm = w && q.size() == D;
    unm = r && !sh;
    @(posedge clock0);
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      rd_m = '0;
      ovm = 1'b0;
      unm = 1'b0;
    end else begin
      if (racc) begin
        rd_m = q[0].d;
        void'(q.pop_front());
      end
      if (wacc) q.push_back('{d: d, t: cyc});
`ifdef FIFO_FWFT_EN
      if (shown()) rd_m = q[0].d;
`endif
    end
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(!shown()));
    check("full", 64'(full), 64'(q.size() == D));
    check("almost_full", 64'(almost_full), 64'(q.size() >= 14));
    check("almost_empty", 64'(almost_empty), 64'(q.size() <= 2));
    check("read_data", 64'(read_data), 64'(rd_m));
    check("overflow", 64'(overflow), 64'(ovm));
    check("underflow", 64'(underflow), 64'(unm));
  endtask
  initial begin
    logic [DW-1:0] d;
    step(1, 0, 0, '0);
    step(1, 1, 1, rnd());
    step(0, 0, 0, '0);
    for (int i = 0; i < 17; i++) begin
      d = rnd();
      d[3:0] = 4'hF;
      step(0, 1, 0, d);
    end
    for (int i = 0; i < 17; i++) step(0, 0, 1, '0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, rnd());
    step(0, 0, 0, '0);
    for (int i = 0; i < 40; i++) step(0, 1, 1, rnd());
    for (int i = 0; i < 20 && q.size() < D; i++) step(0, 1, 0, rnd());
    step(0, 0, 0, '0);
    step(0, 1, 1, rnd());
    for (int i = 0; i < 40 && q.size() > 0; i++) step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    step(0, 1, 1, rnd());
    for (int i = 0; i < 20 && q.size() < 10; i++) step(0, 1, 0, rnd());
    step(1, 1, 1, rnd());
    step(0, 1, 0, DW'(32'hDEADBEEF));
    step(0, 0, 0, '0);
    step(0, 0, 1, '0);
    check("deadbeef", 64'(read_data), 64'(32'hDEADBEEF));
    step(1, 0, 0, '0);
    step(0, 1, 0, DW'(36'hA));
    step(0, 1, 0, DW'(36'hB));
`ifdef FIFO_FWFT_EN
    check("fwft_head_a", 64'(read_data), 64'hA);
    step(0, 1, 1, DW'(36'hC));
    check("fwft_b", 64'(read_data), 64'hB);
    step(0, 0, 1, '0);
    check("fwft_c", 64'(read_data), 64'hC);
    step(0, 0, 1, '0);
    check("fwft_empty", 64'(empty), 64'h1);
`else
    step(0, 1, 1, DW'(36'hC));
    check("std_a", 64'(read_data), 64'hA);
    step(0, 0, 1, '0);
    check("std_b", 64'(read_data), 64'hB);
    step(0, 0, 1, '0);
    check("std_c", 64'(read_data), 64'hC);
    check("std_empty", 64'(empty), 64'h1);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, rnd());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
